// File: rtl/data_bus_decoder_if.sv
// rtl/data_bus_decoder_if.sv - CPU data port and slave-side bus bundle for data_bus_decoder
interface data_bus_decoder_if #(
   parameter int DW   = 32,
   parameter int AW   = 24,
   parameter int SELW = 2,
   parameter int NSLV = 3
);
   logic [AW-1:0]      i_addr;
   logic               i_rd;
   logic               i_wr;
   logic [DW-1:0]      i_wdata;
   logic [DW-1:0]      o_rdata;
   logic               o_rvalid;
   logic               o_err;
   logic [15:0]        o_err_cnt;
   logic [NSLV-1:0]    o_sel;
   logic [AW-SELW-1:0] o_saddr;
   logic [DW-1:0]      o_wdata;
   logic               o_rd;
   logic               o_wr;
   logic [NSLV*DW-1:0] i_rdata;

   modport master (
      output i_addr, i_rd, i_wr, i_wdata, i_rdata,
      input  o_rdata, o_rvalid, o_err, o_err_cnt, o_sel, o_saddr, o_wdata, o_rd, o_wr
   );

   modport slave (
      input  i_addr, i_rd, i_wr, i_wdata, i_rdata,
      output o_rdata, o_rvalid, o_err, o_err_cnt, o_sel, o_saddr, o_wdata, o_rd, o_wr
   );
endinterface

// File: rtl/data_bus_decoder.sv
// rtl/data_bus_decoder.sv - data-bus address decoder and read-return mux; DBUS_ERR_CNT_EN adds error counter
module data_bus_decoder #(
   parameter int          DW        = 32,
   parameter int          AW        = 24,
   parameter int          SELW      = 2,
   parameter int          NSLV      = 3,
   parameter int          RD_LAT    = 1,
   parameter logic [31:0] DEF_RDATA = 32'hDEADBEEF
) (
   input logic                i_clk,
   input logic                i_rst,
   input logic                i_clk_en,
   data_bus_decoder_if.slave  bus
);
   logic [SELW-1:0]   idx;
   logic              req;
   logic              mapped;
   logic              rd_acc;
   logic [NSLV-1:0]   sel;
   logic [DW-1:0]     rdata;
   logic              err;
   logic [RD_LAT-1:0] vld;
   logic [SELW-1:0]   sidx [RD_LAT];
   logic [SELW-1:0]   tidx;

   assign idx    = bus.i_addr[AW-1 -: SELW];
   assign req    = i_clk_en & (bus.i_rd | bus.i_wr);
   assign mapped = (32'(idx) < NSLV);
   assign rd_acc = bus.i_rd & ~bus.i_wr;
   assign tidx   = sidx[RD_LAT-1];

   always_comb begin
      sel = '0;
      for (int k = 0; k < NSLV; k++) begin
         sel[k] = req & ~i_rst & (idx == SELW'(k));
      end
   end

   // Unmapped tail index falls through to the default data word.
   always_comb begin
      rdata = DW'(DEF_RDATA);
      for (int k = 0; k < NSLV; k++) begin
         if (tidx == SELW'(k)) rdata = bus.i_rdata[k*DW +: DW];
      end
   end

   // Index stages only advance with a valid read so o_rdata stays put between reads.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld <= '0;
         err <= 1'b0;
         for (int k = 0; k < RD_LAT; k++) sidx[k] <= '0;
      end else begin
         err <= req & ~mapped;
         if (i_clk_en) begin
            vld[0] <= rd_acc;
            if (rd_acc) sidx[0] <= idx;
            for (int k = 1; k < RD_LAT; k++) begin
               vld[k] <= vld[k-1];
               if (vld[k-1]) sidx[k] <= sidx[k-1];
            end
         end
      end
   end

`ifdef DBUS_ERR_CNT_EN
   logic [15:0] err_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         err_cnt <= 16'h0000;
      end else if (err && err_cnt != 16'hFFFF) begin
         err_cnt <= err_cnt + 16'h0001;
      end
   end

   assign bus.o_err_cnt = err_cnt;
`else
   assign bus.o_err_cnt = 16'h0000;
`endif

   assign bus.o_sel    = sel;
   assign bus.o_saddr  = bus.i_addr[AW-SELW-1:0];
   assign bus.o_wdata  = bus.i_wdata;
   assign bus.o_wr     = bus.i_wr & req & mapped & ~i_rst;
   assign bus.o_rd     = rd_acc & req & mapped & ~i_rst;
   assign bus.o_rvalid = vld[RD_LAT-1] & i_clk_en;
   assign bus.o_rdata  = rdata;
   assign bus.o_err    = err;
endmodule

// File: tb/tb_data_bus_decoder.sv
// tb/tb_data_bus_decoder.sv - directed self-checking bench for data_bus_decoder at RD_LAT 1, 2 and 3
module tb_data_bus_decoder;
   localparam logic [31:0] SLV1 = 32'hBBBB_1111;
   localparam logic [31:0] SLV2 = 32'hCCCC_2222;
`ifdef DBUS_ERR_CNT_EN
   localparam logic [15:0] CNT1 = 16'h0001;
   localparam logic [15:0] CNT2 = 16'h0002;
`else
   localparam logic [15:0] CNT1 = 16'h0000;
   localparam logic [15:0] CNT2 = 16'h0000;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b1;
   logic [23:0] addr = '0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] ram0 = 32'h0;

   logic [2:0]  rvalid, rdo, wro, err;
   logic [2:0]  sel [3];
   logic [31:0] rdata [3];
   logic [15:0] cnt [3];
   logic [21:0] saddr0;
   logic [31:0] wdo0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      data_bus_decoder_if #(.DW(32), .AW(24), .SELW(2), .NSLV(3)) bus ();
      assign bus.i_addr  = addr;
      assign bus.i_rd    = rd;
      assign bus.i_wr    = wr;
      assign bus.i_wdata = wdata;
      assign bus.i_rdata = {SLV2, SLV1, ram0};
      assign rvalid[g]   = bus.o_rvalid;
      assign rdo[g]      = bus.o_rd;
      assign wro[g]      = bus.o_wr;
      assign err[g]      = bus.o_err;
      assign sel[g]      = bus.o_sel;
      assign rdata[g]    = bus.o_rdata;
      assign cnt[g]      = bus.o_err_cnt;
      data_bus_decoder #(.RD_LAT(g + 1)) dut (
         .i_clk    (clk),
         .i_rst    (rst),
         .i_clk_en (clk_en),
         .bus      (bus)
      );
   end

   assign saddr0 = gen_dut[0].bus.o_saddr;
   assign wdo0   = gen_dut[0].bus.o_wdata;

   // Slave 0 is a one-word RAM written through the RD_LAT=1 instance.
   always_ff @(posedge clk) begin
      if (wro[0] && sel[0][0]) ram0 <= wdo0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic w, input logic [23:0] a,
                      input logic [31:0] d, input logic en);
      @(posedge clk);
      #1;
      rd = r; wr = w; addr = a; wdata = d; clk_en = en;
      #1;
   endtask

   initial begin
      // reset, with a read presented that must not be forwarded
      rst = 1'b1;
      cyc(1, 0, 24'h000010, 0, 1);
      cyc(1, 0, 24'h000010, 0, 1);
      chk("rst_sel", 32'(sel[0]), 0);
      chk("rst_rd", 32'(rdo[0]), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_err", 32'(err), 0);
      rst = 1'b0;
      cyc(0, 0, 0, 0, 1);
      chk("idle_rdata_slv0", rdata[0], 32'h0);
      chk("idle_cnt", 32'(cnt[0]), 0);

      // write then read back at RD_LAT=1
      cyc(0, 1, 24'h000010, 32'h12345678, 1);
      chk("wr_sel", 32'(sel[0]), 32'b001);
      chk("wr_wr", 32'(wro[0]), 1);
      chk("wr_rd", 32'(rdo[0]), 0);
      chk("wr_saddr", 32'(saddr0), 32'h10);
      chk("wr_wdata", wdo0, 32'h12345678);
      cyc(1, 0, 24'h000010, 0, 1);
      chk("rd_sel", 32'(sel[0]), 32'b001);
      chk("rd_rd", 32'(rdo[0]), 1);
      chk("rd_rvalid_early", 32'(rvalid[0]), 0);
      cyc(0, 0, 0, 0, 1);
      chk("rd1_rvalid", 32'(rvalid[0]), 1);
      chk("rd1_rdata", rdata[0], 32'h12345678);
      chk("rd2_not_yet", 32'(rvalid[1]), 0);
      cyc(0, 0, 0, 0, 1);
      chk("rd1_rvalid_end", 32'(rvalid[0]), 0);
      chk("rd2_rvalid", 32'(rvalid[1]), 1);
      chk("rd2_rdata", rdata[1], 32'h12345678);
      repeat (3) cyc(0, 0, 0, 0, 1);

      // back-to-back reads to slaves 0,1,2
      cyc(1, 0, 24'h000020, 0, 1);
      chk("b2b_sel0", 32'(sel[1]), 32'b001);
      cyc(1, 0, 24'h400004, 0, 1);
      chk("b2b_sel1", 32'(sel[1]), 32'b010);
      chk("b2b_lat1_data", rdata[0], 32'h12345678);
      cyc(1, 0, 24'h800008, 0, 1);
      chk("b2b_sel2", 32'(sel[1]), 32'b100);
      chk("b2b_v_a", 32'(rvalid[1]), 1);
      chk("b2b_d_a", rdata[1], 32'h12345678);
      cyc(0, 0, 0, 0, 1);
      chk("b2b_v_b", 32'(rvalid[1]), 1);
      chk("b2b_d_b", rdata[1], SLV1);
      cyc(0, 0, 0, 0, 1);
      chk("b2b_v_c", 32'(rvalid[1]), 1);
      chk("b2b_d_c", rdata[1], SLV2);
      cyc(0, 0, 0, 0, 1);
      chk("b2b_v_end", 32'(rvalid[1]), 0);
      chk("b2b_d_held", rdata[1], SLV2);
      chk("b2b_lat3_v", 32'(rvalid[2]), 1);
      chk("b2b_lat3_d", rdata[2], SLV2);
      cyc(0, 0, 0, 0, 1);
      chk("b2b_lat3_end", 32'(rvalid[2]), 0);

      // unmapped read and write
      cyc(1, 0, 24'hC00000, 0, 1);
      chk("unm_sel", 32'(sel[0]), 0);
      chk("unm_rd", 32'(rdo[0]), 0);
      chk("unm_err_early", 32'(err[0]), 0);
      cyc(0, 0, 0, 0, 1);
      chk("unm_err", 32'(err[0]), 1);
      chk("unm_v1", 32'(rvalid[0]), 1);
      chk("unm_d1", rdata[0], 32'hDEADBEEF);
      cyc(0, 0, 0, 0, 1);
      chk("unm_err_end", 32'(err[0]), 0);
      chk("unm_v2", 32'(rvalid[1]), 1);
      chk("unm_d2", rdata[1], 32'hDEADBEEF);
      chk("unm_cnt1", 32'(cnt[0]), 32'(CNT1));
      cyc(0, 0, 0, 0, 1);
      chk("unm_v3", 32'(rvalid[2]), 1);
      chk("unm_d3", rdata[2], 32'hDEADBEEF);
      cyc(0, 1, 24'hC00004, 32'h1, 1);
      chk("unm_wr_wr", 32'(wro[0]), 0);
      chk("unm_wr_sel", 32'(sel[0]), 0);
      cyc(0, 0, 0, 0, 1);
      chk("unm_wr_err", 32'(err[0]), 1);
      cyc(0, 0, 0, 0, 1);
      chk("unm_cnt2", 32'(cnt[0]), 32'(CNT2));

      // freeze in the middle of an RD_LAT=3 read
      cyc(1, 0, 24'h400000, 0, 1);
      cyc(0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 24'h800000, 0, 0);
         chk("frz_sel", 32'(sel[2]), 0);
         chk("frz_rd", 32'(rdo[2]), 0);
         chk("frz_rvalid", 32'(rvalid), 0);
      end
      cyc(0, 0, 0, 0, 1);
      chk("frz_v_wait", 32'(rvalid[2]), 0);
      cyc(0, 0, 0, 0, 1);
      chk("frz_v", 32'(rvalid[2]), 1);
      chk("frz_d", rdata[2], SLV1);
      cyc(0, 0, 0, 0, 1);
      chk("frz_v_end", 32'(rvalid[2]), 0);

      // reset one cycle after an RD_LAT=3 read
      cyc(1, 0, 24'h000000, 0, 1);
      rst = 1'b1;
      cyc(0, 0, 0, 0, 1);
      chk("rstm_v0", 32'(rvalid[2]), 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 1);
         chk("rstm_v", 32'(rvalid[2]), 0);
      end
      chk("rstm_cnt", 32'(cnt[0]), 0);
      chk("rstm_rdata_slv0", rdata[2], 32'h12345678);

      // read/write collision to slave 1
      cyc(1, 1, 24'h400000, 32'h55, 1);
      chk("col_wr", 32'(wro[0]), 1);
      chk("col_rd", 32'(rdo[0]), 0);
      chk("col_sel", 32'(sel[0]), 32'b010);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 1);
         chk("col_rvalid", 32'(rvalid), 0);
      end

`ifdef DBUS_ERR_CNT_EN
      for (int i = 0; i < 65540; i++) cyc(0, 1, 24'hC00000, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      chk("sat_cnt", 32'(cnt[0]), 32'h0000FFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
